// File: rtl/sas_pkg.sv
// Shared types and constants for the ADD_SEQ input-side sequencer.
package sas_pkg;

    localparam int SAS_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SETTLE,
        DONE
    } sas_state_t;

    // Bit-counter width; a one-bit job still needs a one-bit counter.
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sas_seq_ctrl_if.sv
// Host-side job and result handshakes of the sequencer.
interface sas_seq_ctrl_if import sas_pkg::*; #(parameter int WIDTH = SAS_WIDTH);

    logic             StartValid;
    logic             StartReady;
    logic [WIDTH-1:0] Coeff;
    logic [WIDTH-1:0] Operand;
    logic             ResultValid;
    logic             ResultReady;
    logic [WIDTH-1:0] Result;

    modport master (
        output StartValid, Coeff, Operand, ResultReady,
        input  StartReady, ResultValid, Result
    );

    modport slave (
        input  StartValid, Coeff, Operand, ResultReady,
        output StartReady, ResultValid, Result
    );

endinterface

// File: rtl/sas_piso.sv
// Parallel-in serial-out register; serialOut always shows the next bit to send.
module sas_piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             shiftEnable,
    input  logic [WIDTH-1:0] parallelIn,
    output logic             serialOut
);

    logic [WIDTH-1:0] shiftReg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shiftReg <= '0;
        end else if (load) begin
            shiftReg <= parallelIn;
        end else if (shiftEnable) begin
            shiftReg <= MSB_FIRST ? (shiftReg << 1) : (shiftReg >> 1);
        end
    end

    assign serialOut = MSB_FIRST ? shiftReg[WIDTH-1] : shiftReg[0];

endmodule

// File: rtl/sas_seq_ctrl.sv
// Drives ADD_SEQ: accepts a job, loads the coefficient, streams the operand
// bit-serially, then holds the sampled product on the result handshake.
module sas_seq_ctrl import sas_pkg::*; #(
    parameter int WIDTH     = SAS_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    sas_seq_ctrl_if.slave    host,
    output logic             ParaLoad,
    output logic [WIDTH-1:0] CoeffData,
    output logic             SerialIn,
    output logic             EnableShiftAdd,
    input  logic [WIDTH-1:0] ParallelOut,
    output logic             Busy
);

    localparam int            CW       = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sas_state_t       state, nextState;
    logic [CW-1:0]    bitCnt;
    logic [WIDTH-1:0] coeffReg;
    logic [WIDTH-1:0] resultReg;
    logic             outOfReset;
    logic             idleReady;
    logic             accept;
    logic             pisoBit;

    // StartReady stays low until the first clock edge after reset release.
    assign idleReady = (state == IDLE) && outOfReset;
    assign accept    = host.StartValid && idleReady;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            outOfReset <= 1'b0;
        end else begin
            state      <= nextState;
            outOfReset <= 1'b1;
        end
    end

    always_comb begin
        nextState        = state;
        ParaLoad         = 1'b0;
        EnableShiftAdd   = 1'b0;
        SerialIn         = 1'b0;
        host.ResultValid = 1'b0;
        host.StartReady  = idleReady;
        Busy             = (state != IDLE);
        case (state)
            IDLE:   if (accept) nextState = LOAD;
            LOAD: begin
                ParaLoad  = 1'b1;
                nextState = SHIFT;
            end
            SHIFT: begin
                EnableShiftAdd = 1'b1;
                SerialIn       = pisoBit;
                if (bitCnt == LAST_CNT) nextState = SETTLE;
            end
            SETTLE: nextState = DONE;
            DONE: begin
                host.ResultValid = 1'b1;
                if (host.ResultReady) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Coefficient is held from acceptance; the result only changes on the SETTLE edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            coeffReg  <= '0;
            resultReg <= '0;
            bitCnt    <= '0;
        end else begin
            if (accept) coeffReg <= host.Coeff;
            if (state == LOAD) begin
                bitCnt <= '0;
            end else if (state == SHIFT && bitCnt != LAST_CNT) begin
                bitCnt <= bitCnt + 1'b1;
            end
            if (state == SETTLE) resultReg <= ParallelOut;
        end
    end

    assign CoeffData   = coeffReg;
    assign host.Result = resultReg;

    sas_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) operandPiso (
        .Clock       (Clock),
        .Reset       (Reset),
        .load        (accept),
        .shiftEnable (state == SHIFT),
        .parallelIn  (host.Operand),
        .serialOut   (pisoBit)
    );

endmodule

// File: tb/tb_sas_seq_ctrl.sv
// Directed bench: MSB-first and LSB-first controllers run in lockstep, each
// driving a behavioural ADD_SEQ shift-add accumulator.
module tb_sas_seq_ctrl;
    import sas_pkg::*;

    localparam int WIDTH = SAS_WIDTH;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    sas_seq_ctrl_if #(.WIDTH(WIDTH)) hostM ();
    sas_seq_ctrl_if #(.WIDTH(WIDTH)) hostL ();

    logic             paraLoadM, serialInM, enableM, busyM;
    logic             paraLoadL, serialInL, enableL, busyL;
    logic [WIDTH-1:0] coeffDataM, coeffDataL;
    logic [WIDTH-1:0] parallelOutM = '0;
    logic [WIDTH-1:0] parallelOutL = '0;
    logic [WIDTH-1:0] modelCoeffM  = '0;
    logic [WIDTH-1:0] modelCoeffL  = '0;

    assign hostL.StartValid  = hostM.StartValid;
    assign hostL.Coeff       = hostM.Coeff;
    assign hostL.Operand     = hostM.Operand;
    assign hostL.ResultReady = hostM.ResultReady;

    sas_seq_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutM (
        .Clock          (Clock),
        .Reset          (Reset),
        .host           (hostM),
        .ParaLoad       (paraLoadM),
        .CoeffData      (coeffDataM),
        .SerialIn       (serialInM),
        .EnableShiftAdd (enableM),
        .ParallelOut    (parallelOutM),
        .Busy           (busyM)
    );

    sas_seq_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutL (
        .Clock          (Clock),
        .Reset          (Reset),
        .host           (hostL),
        .ParaLoad       (paraLoadL),
        .CoeffData      (coeffDataL),
        .SerialIn       (serialInL),
        .EnableShiftAdd (enableL),
        .ParallelOut    (parallelOutL),
        .Busy           (busyL)
    );

    // ADD_SEQ: acc = 2*acc + bit*coeff per enabled cycle, cleared on load; never reset.
    always @(posedge Clock) begin
        if (paraLoadM) begin
            modelCoeffM  <= coeffDataM;
            parallelOutM <= '0;
        end else if (enableM) begin
            parallelOutM <= (parallelOutM << 1) + (serialInM ? modelCoeffM : '0);
        end
        if (paraLoadL) begin
            modelCoeffL  <= coeffDataL;
            parallelOutL <= '0;
        end else if (enableL) begin
            parallelOutL <= (parallelOutL << 1) + (serialInL ? modelCoeffL : '0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] coeff, input logic [WIDTH-1:0] operand);
        hostM.StartValid = 1'b1;
        hostM.Coeff      = coeff;
        hostM.Operand    = operand;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [WIDTH-1:0] msbSeq, lsbSeq;
    logic             sawValid;
    int               nPara, nValid;
    int               paraAt [3];
    int               validAt[3];
    logic [WIDTH-1:0] jobCoeff[3] = '{8'h00, 8'h07, 8'h03};
    logic [WIDTH-1:0] jobOp   [3] = '{8'hAB, 8'h00, 8'h0B};
    logic [WIDTH-1:0] jobExpM [3] = '{8'h00, 8'h00, 8'h21};
    logic [WIDTH-1:0] jobExpL [3] = '{8'h00, 8'h00, 8'h70};

    initial begin
        hostM.StartValid  = 1'b0;
        hostM.Coeff       = '0;
        hostM.Operand     = '0;
        hostM.ResultReady = 1'b0;

        // Reset values while Reset is held.
        repeat (2) tick();
        checkOutput("resetStrobesM", {paraLoadM, enableM, serialInM, hostM.ResultValid, busyM, hostM.StartReady}, 6'b0);
        checkOutput("resetStrobesL", {paraLoadL, enableL, serialInL, hostL.ResultValid, busyL, hostL.StartReady}, 6'b0);
        checkOutput("resetDataM", {coeffDataM, hostM.Result}, 16'h0000);
        Reset = 1'b0;
        tick();
        checkOutput("readyAfterRelease", hostM.StartReady, 1'b1);
        repeat (5) begin
            tick();
            checkOutput("idleOutputs", {hostM.StartReady, busyM, paraLoadM, enableM, serialInM, hostM.ResultValid}, 6'b100000);
        end

        // Single job, both bit orders.
        msbSeq = 8'b1011_0010;
        lsbSeq = 8'b0100_1101;
        applyStimulus(8'h56, 8'hB2);
        tick();
        hostM.StartValid = 1'b0;
        checkOutput("loadStrobe", {paraLoadM, paraLoadL, enableM, busyM, hostM.StartReady}, 5'b11010);
        checkOutput("coeffData", coeffDataM, 8'h56);
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            checkOutput("shiftEnable", {enableM, enableL, paraLoadM}, 3'b110);
            checkOutput("serialMsb", serialInM, msbSeq[WIDTH-1-i]);
            checkOutput("serialLsb", serialInL, lsbSeq[WIDTH-1-i]);
        end
        tick();
        checkOutput("settle", {enableM, serialInM, hostM.ResultValid, busyM}, 4'b0001);
        tick();
        checkOutput("validAt11", {hostM.ResultValid, hostL.ResultValid}, 2'b11);
        checkOutput("resultMsb", hostM.Result, 8'hCC);
        checkOutput("resultLsb", hostL.Result, 8'hDE);
        hostM.ResultReady = 1'b1;
        tick();
        hostM.ResultReady = 1'b0;
        checkOutput("backToIdle", {hostM.ResultValid, busyM, hostM.StartReady}, 3'b001);

        // Second job offered during SHIFT, result acceptance delayed.
        applyStimulus(8'h03, 8'h05);
        tick();
        repeat (2) tick();
        applyStimulus(8'h11, 8'h0F);
        repeat (WIDTH) begin
            tick();
            checkOutput("busyNotReady", {hostM.StartReady, paraLoadM}, 2'b00);
            checkOutput("coeffHeld", coeffDataM, 8'h03);
        end
        checkOutput("jobAValid", hostM.ResultValid, 1'b1);
        checkOutput("jobAMsb", hostM.Result, 8'h0F);
        checkOutput("jobALsb", hostL.Result, 8'hE0);
        repeat (5) begin
            tick();
            checkOutput("waitHold", {hostM.ResultValid, hostM.StartReady, hostM.Result}, {2'b10, 8'h0F});
        end
        hostM.ResultReady = 1'b1;
        tick();
        hostM.ResultReady = 1'b0;
        checkOutput("idleBetween", {hostM.StartReady, busyM, hostM.ResultValid, paraLoadM}, 4'b1000);
        tick();
        hostM.StartValid = 1'b0;
        checkOutput("jobBLoad", {paraLoadM, coeffDataM}, {1'b1, 8'h11});
        repeat (WIDTH + 2) tick();
        checkOutput("jobBValid", hostM.ResultValid, 1'b1);
        checkOutput("jobBMsb", hostM.Result, 8'hFF);
        checkOutput("jobBLsb", hostL.Result, 8'hF0);
        hostM.ResultReady = 1'b1;
        tick();
        hostM.ResultReady = 1'b0;

        // Reset asserted in the fourth SHIFT cycle.
        applyStimulus(8'h5A, 8'hFF);
        tick();
        hostM.StartValid = 1'b0;
        repeat (4) tick();
        checkOutput("preResetShift", {enableM, serialInM, enableL, serialInL}, 4'b1111);
        Reset = 1'b1;
        #1;
        checkOutput("asyncDropM", {enableM, serialInM, busyM, hostM.ResultValid, hostM.StartReady}, 5'b0);
        checkOutput("asyncDropL", {enableL, serialInL, busyL, hostL.ResultValid}, 4'b0);
        tick();
        Reset = 1'b0;
        sawValid = 1'b0;
        repeat (15) begin
            tick();
            sawValid = sawValid | hostM.ResultValid | hostL.ResultValid;
        end
        checkOutput("noValidAfterReset", sawValid, 1'b0);
        checkOutput("idleAfterReset", {hostM.StartReady, busyM}, 2'b10);

        // Three back-to-back jobs with ResultReady tied high.
        nPara  = 0;
        nValid = 0;
        hostM.ResultReady = 1'b1;
        applyStimulus(jobCoeff[0], jobOp[0]);
        for (int cyc = 0; cyc < 60; cyc++) begin
            tick();
            if (paraLoadM) begin
                if (nPara < 3) paraAt[nPara] = cyc;
                nPara++;
                if (nPara < 3) applyStimulus(jobCoeff[nPara], jobOp[nPara]);
                else hostM.StartValid = 1'b0;
            end
            if (hostM.ResultValid) begin
                if (nValid < 3) begin
                    validAt[nValid] = cyc;
                    checkOutput("b2bResultMsb", hostM.Result, jobExpM[nValid]);
                    checkOutput("b2bResultLsb", hostL.Result, jobExpL[nValid]);
                end
                nValid++;
            end
        end
        hostM.StartValid  = 1'b0;
        hostM.ResultReady = 1'b0;
        checkOutput("b2bJobCount", nPara, 3);
        checkOutput("b2bValidCycles", nValid, 3);
        checkOutput("b2bPeriod1", paraAt[1] - paraAt[0], 12);
        checkOutput("b2bPeriod2", paraAt[2] - paraAt[1], 12);
        for (int j = 0; j < 3; j++) begin
            checkOutput("b2bLatency", validAt[j] - paraAt[j], 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sas_seq_ctrl.md
# sas_seq_ctrl

Sequencer that drives the serial shift-add unit `ADD_SEQ` from its input side and collects its result. It accepts a coefficient/operand pair on a valid/ready handshake, issues a one-cycle parallel coefficient load, then streams the operand bit-serially under `EnableShiftAdd`. It samples `ParallelOut` after one settle cycle and presents the product on a valid/ready result handshake. It sits between a host register interface and `ADD_SEQ`.

## Interface
- `WIDTH`, 8, coefficient/operand/result width; also the number of serial bits.
- `MSB_FIRST`, 1, 1 = operand shifted out MSB first; 0 = LSB first.

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  reset, asynchronous, active-high.
- `StartValid`  in  1  host presents a job.
- `StartReady`  out  1  block can accept a job.
- `Coeff`  in  WIDTH  coefficient for the job.
- `Operand`  in  WIDTH  operand to serialize.
- `ParaLoad`  out  1  to `ADD_SEQ`; one-cycle coefficient load strobe.
- `CoeffData`  out  WIDTH  to `ADD_SEQ`; captured coefficient.
- `SerialIn`  out  1  to `ADD_SEQ`; current operand bit.
- `EnableShiftAdd`  out  1  to `ADD_SEQ`; shift/add enable.
- `ParallelOut`  in  WIDTH  from `ADD_SEQ`; accumulated result.
- `ResultValid`  out  1  `Result` is valid.
- `ResultReady`  in  1  host accepts the result.
- `Result`  out  WIDTH  captured `ParallelOut`.
- `Busy`  out  1  high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, LOAD, SHIFT, SETTLE, DONE.
- **IDLE**
  - `StartReady`=1.
  - On `StartValid`&&`StartReady`: capture `Coeff` into the coeff register and `Operand` into the shift register; go to LOAD.
- **LOAD**
  - `ParaLoad`=1 for exactly one cycle.
  - `CoeffData`=coeff register.
  - Bit counter cleared to 0; go to SHIFT.
- **SHIFT**
  - `EnableShiftAdd`=1.
  - `SerialIn` = operand bit `[WIDTH-1-cnt]` if `MSB_FIRST`, else `[cnt]`.
  - Counter increments each cycle.
  - After `WIDTH` cycles (cnt==`WIDTH`-1 on the edge), go to SETTLE.
- **SETTLE**
  - `EnableShiftAdd`=0, `SerialIn`=0.
  - `ParallelOut` is sampled into `Result` on the closing edge; go to DONE.
- **DONE**
  - `ResultValid`=1; `Result` held stable.
  - On `ResultReady`: go to IDLE.
- **Signal rules**
  - `SerialIn`=0 outside SHIFT.
  - `CoeffData` holds its value from LOAD until the next job is accepted.
  - `Result` holds until the next SETTLE.
- **Arithmetic:** no arithmetic in this block. The counter width is `$clog2(WIDTH)`. Counter wrap is never reached, because the exit condition is compared at `WIDTH`-1.
- **Boundary conditions**
  - `StartValid` while `Busy`: ignored, and `StartReady`=0.
  - `ResultReady` high in the first DONE cycle: accepted; IDLE on the next cycle.
  - `ResultReady` high outside DONE: no effect.
  - Operand=0 or Coeff=0: full sequence still runs (fixed latency).
  - Reset mid-operation: the FSM asynchronously returns to IDLE and all strobes drop immediately. `ADD_SEQ` is not reset by this block.

## Timing
- **Reset values:**
  - `StartReady`=0 while `Reset` is asserted, 1 from the first edge after release (IDLE).
  - `ParaLoad`, `EnableShiftAdd`, `SerialIn`, `ResultValid` and `Busy` are 0.
  - `CoeffData` and `Result` are 0.
- **Registered outputs:** all outputs are decoded from registered state only. There is no combinational path from any input to any output.
- **Job timeline, with the job accepted on edge k:**
  - `ParaLoad` is high in cycle k+1.
  - `EnableShiftAdd` is high in cycles k+2 .. k+1+`WIDTH`.
  - SETTLE occupies cycle k+2+`WIDTH`.
  - `ResultValid` is high from cycle k+3+`WIDTH`.
- **Latency:** accept-to-`ResultValid` is `WIDTH`+3 cycles.
- **Throughput:** minimum job period is `WIDTH`+4 cycles (one IDLE cycle between jobs).

## Structure
- **Package `sas_pkg`**
  - State enum `sas_state_t` (IDLE, LOAD, SHIFT, SETTLE, DONE).
  - Default `SAS_WIDTH`=8.
  - Counter-width function.
- **Sub-module `sas_piso`**
  - Parallel-in serial-out register with load, shift enable and the `MSB_FIRST` parameter.
  - Instantiated once for the operand.
- **Top level:** the FSM, the coeff/result registers and the counter stay in `sas_seq_ctrl`.

## Test plan
- Reset released, no stimulus -> `StartReady`=1, `Busy`=0, all `ADD_SEQ`-side outputs 0 indefinitely.
- Coeff=8'h56, Operand=8'hB2, `MSB_FIRST`=1 -> `CoeffData`=8'h56 with a one-cycle `ParaLoad`, then `SerialIn`=1,0,1,1,0,0,1,0 over 8 `EnableShiftAdd` cycles. `ResultValid` arrives 11 cycles after accept, with `Result` equal to the behavioural `ADD_SEQ` model output.
- Same job with `MSB_FIRST`=0 -> `SerialIn`=0,1,0,0,1,1,0,1.
- `StartValid` held high with a second job during SHIFT; `ResultReady` delayed 5 cycles -> second job not accepted until IDLE, `Result` stable while waiting, second job starts 1 cycle after IDLE.
- `Reset` asserted in the 4th SHIFT cycle -> `EnableShiftAdd` and `SerialIn` drop asynchronously, FSM in IDLE, `ResultValid` never asserted.
- `ResultReady` tied high, 3 back-to-back jobs -> period exactly 12 cycles each, with `ResultValid` high for one cycle per job.
